// File: rtl/character_sprite_renderer_pkg.sv
// Shared display-ID codes, sprite geometry and colour key for the character sprite path.
package character_sprite_renderer_pkg;

    localparam logic [2:0] IDLE_DIS_1      = 3'd0;
    localparam logic [2:0] IDLE_DIS_2      = 3'd1;
    localparam logic [2:0] RUN_DIS_1       = 3'd2;
    localparam logic [2:0] RUN_DIS_2       = 3'd3;
    localparam logic [2:0] JUMP_DIS        = 3'd4;
    localparam logic [2:0] FALL_DIS        = 3'd5;
    localparam logic [2:0] SAFE_GROUND_DIS = 3'd6;

    localparam int          SPRITE_W          = 32;
    localparam int          SPRITE_H          = 32;
    localparam logic [11:0] TRANSPARENT_COLOR = 12'hF0F;

    // Per-stage pixel tag travelling alongside the ROM lookup.
    typedef struct packed {
        logic vld;
        logic cand;
    } pix_stage_t;

endpackage

// File: rtl/character_sprite_bbox.sv
// Combinational sprite hit test, horizontal mirroring and sprite ROM address generation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle from the current pixel and shadow state.
module character_sprite_bbox #(
    parameter int COORD_WIDTH    = 10,
    parameter int SPRITE_W       = 32,
    parameter int SPRITE_H       = 32,
    parameter int NUM_SPRITES    = 7,
    parameter int ROM_ADDR_WIDTH = $clog2(NUM_SPRITES * SPRITE_W * SPRITE_H)
) (
    input  logic [COORD_WIDTH-1:0]    pix_x,
    input  logic [COORD_WIDTH-1:0]    pix_y,
    input  logic [COORD_WIDTH-1:0]    sx,
    input  logic [COORD_WIDTH-1:0]    sy,
    input  logic [2:0]                id,
    input  logic                      face_left,
    output logic                      hit_cand,
    output logic [ROM_ADDR_WIDTH-1:0] addr
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);

    logic [COORD_WIDTH:0] x_end;
    logic [COORD_WIDTH:0] y_end;
    logic                 in_box;
    logic                 id_ok;
    logic [CW-1:0]        col_raw;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;

    always_comb begin
        // One extra bit on the box end so a sprite near the screen edge never wraps to 0.
        x_end   = {1'b0, sx} + (COORD_WIDTH+1)'(SPRITE_W);
        y_end   = {1'b0, sy} + (COORD_WIDTH+1)'(SPRITE_H);
        in_box  = ({1'b0, pix_x} >= {1'b0, sx}) && ({1'b0, pix_x} < x_end) &&
                  ({1'b0, pix_y} >= {1'b0, sy}) && ({1'b0, pix_y} < y_end);
        col_raw = CW'(pix_x - sx);
        col     = face_left ? (CW'(SPRITE_W - 1) - col_raw) : col_raw;
        row     = RW'(pix_y - sy);
        id_ok   = int'(id) < NUM_SPRITES;
        hit_cand = in_box && id_ok;
        addr     = '0;
        if (hit_cand) begin
            addr = ROM_ADDR_WIDTH'(id)  * ROM_ADDR_WIDTH'(SPRITE_W * SPRITE_H)
                 + ROM_ADDR_WIDTH'(row) * ROM_ADDR_WIDTH'(SPRITE_W)
                 + ROM_ADDR_WIDTH'(col);
        end
    end

endmodule

// File: rtl/character_sprite_renderer.sv
// Per-pixel character sprite lookup against an external synchronous ROM, with per-frame shadowing.
// Latency: 3 cycles pix_valid -> out_valid, one pixel per cycle.
// Backpressure: none; the pixel stream is never stalled, gaps propagate as out_valid=0.
module character_sprite_renderer #(
    parameter int                 COORD_WIDTH       = 10,
    parameter int                 SPRITE_W          = character_sprite_renderer_pkg::SPRITE_W,
    parameter int                 SPRITE_H          = character_sprite_renderer_pkg::SPRITE_H,
    parameter int                 NUM_SPRITES       = 7,
    parameter int                 COLOR_WIDTH       = 12,
    parameter logic [COLOR_WIDTH-1:0] TRANSPARENT_COLOR = character_sprite_renderer_pkg::TRANSPARENT_COLOR,
    parameter int                 ROM_ADDR_WIDTH    = $clog2(NUM_SPRITES * SPRITE_W * SPRITE_H)
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      frame_start,
    input  logic [2:0]                char_display_id,
    input  logic                      char_face_left,
    input  logic [COORD_WIDTH-1:0]    char_x,
    input  logic [COORD_WIDTH-1:0]    char_y,
    input  logic                      pix_valid,
    input  logic [COORD_WIDTH-1:0]    pix_x,
    input  logic [COORD_WIDTH-1:0]    pix_y,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [COLOR_WIDTH-1:0]    rom_data,
    output logic                      out_valid,
    output logic                      out_hit,
    output logic [COLOR_WIDTH-1:0]    out_color
);

    import character_sprite_renderer_pkg::*;

    logic [2:0]                sh_id;
    logic                      sh_face_left;
    logic [COORD_WIDTH-1:0]    sh_x;
    logic [COORD_WIDTH-1:0]    sh_y;
    logic                      bb_cand;
    logic [ROM_ADDR_WIDTH-1:0] bb_addr;
    pix_stage_t                s1;
    pix_stage_t                s2;
    logic                      opaque;

    character_sprite_bbox #(
        .COORD_WIDTH    (COORD_WIDTH),
        .SPRITE_W       (SPRITE_W),
        .SPRITE_H       (SPRITE_H),
        .NUM_SPRITES    (NUM_SPRITES),
        .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH)
    ) u_bbox (
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .sx        (sh_x),
        .sy        (sh_y),
        .id        (sh_id),
        .face_left (sh_face_left),
        .hit_cand  (bb_cand),
        .addr      (bb_addr)
    );

    assign opaque = s2.cand && (rom_data != TRANSPARENT_COLOR);

    // The bbox reads the registered shadow, so a pixel coinciding with frame_start sees the old frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sh_id        <= IDLE_DIS_1;
            sh_face_left <= 1'b0;
            sh_x         <= '0;
            sh_y         <= '0;
            s1           <= '0;
            s2           <= '0;
            rom_addr     <= '0;
            out_valid    <= 1'b0;
            out_hit      <= 1'b0;
            out_color    <= '0;
        end else begin
            if (frame_start) begin
                sh_id        <= char_display_id;
                sh_face_left <= char_face_left;
                sh_x         <= char_x;
                sh_y         <= char_y;
            end
            s1.vld    <= pix_valid;
            s1.cand   <= pix_valid && bb_cand;
            rom_addr  <= pix_valid ? bb_addr : '0;
            s2        <= s1;
            out_valid <= s2.vld;
            out_hit   <= opaque;
            out_color <= opaque ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_character_sprite_renderer.sv
// Directed bench for character_sprite_renderer with a behavioural synchronous sprite ROM.
module tb_character_sprite_renderer;

    logic        sys_clk;
    logic        sys_rst;
    logic        frame_start;
    logic [2:0]  char_display_id;
    logic        char_face_left;
    logic [9:0]  char_x;
    logic [9:0]  char_y;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic        out_valid;
    logic        out_hit;
    logic [11:0] out_color;
    logic        rom_force_key;

    int n_vec;
    int n_err;

    character_sprite_renderer dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .frame_start     (frame_start),
        .char_display_id (char_display_id),
        .char_face_left  (char_face_left),
        .char_x          (char_x),
        .char_y          (char_y),
        .pix_valid       (pix_valid),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .out_valid       (out_valid),
        .out_hit         (out_hit),
        .out_color       (out_color)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ROM contents: colour = {0, addr[10:0] ^ 11'h123}; bit 11 clear so never the colour key.
    always @(posedge sys_clk)
        rom_data <= rom_force_key ? 12'hF0F : {1'b0, rom_addr[10:0] ^ 11'h123};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic frame(input int id, input int face, input int x, input int y);
        char_display_id = 3'(id);
        char_face_left  = 1'(face);
        char_x          = 10'(x);
        char_y          = 10'(y);
        frame_start     = 1'b1;
        step();
        frame_start     = 1'b0;
    endtask

    task automatic run_pix(input string tag, input int x, input int y, input int with_fs,
                           input int exp_addr, input int exp_hit, input int exp_col);
        pix_x       = 10'(x);
        pix_y       = 10'(y);
        pix_valid   = 1'b1;
        frame_start = 1'(with_fs);
        step();
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
        step();
        chk({tag, ".early"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
        chk({tag, ".hit"}, 32'(out_hit), 32'(exp_hit));
        chk({tag, ".col"}, 32'(out_color), 32'(exp_col));
    endtask

    // Back-to-back stream with a gap; -1 in x marks an idle cycle.
    int st_x[5]   = '{100, 101, 99, -1, 100};
    int st_y[5]   = '{50, 50, 50, 0, 51};
    int st_hit[5] = '{1, 1, 0, 0, 1};
    int st_col[5] = '{'h123, 'h122, 0, 0, 'h103};

    initial begin
        n_vec = 0;
        n_err = 0;
        sys_rst = 1'b1;
        frame_start = 1'b0;
        char_display_id = 3'd0;
        char_face_left = 1'b0;
        char_x = '0;
        char_y = '0;
        pix_valid = 1'b0;
        pix_x = '0;
        pix_y = '0;
        rom_force_key = 1'b0;
        step();
        step();
        sys_rst = 1'b0;
        chk("rst.vld", 32'(out_valid), 32'd0);
        chk("rst.hit", 32'(out_hit), 32'd0);
        chk("rst.col", 32'(out_color), 32'd0);
        chk("rst.addr", 32'(rom_addr), 32'd0);
        run_pix("rst_shadow", 0, 0, 0, 0, 1, 'h123);

        frame(2, 0, 100, 50);
        run_pix("base", 100, 50, 0, 2048, 1, 'h123);
        run_pix("right_col", 131, 50, 0, 2079, 1, 'h13C);
        run_pix("bot_row", 100, 81, 0, 3040, 1, 'h2C3);
        run_pix("miss_r", 132, 50, 0, 0, 0, 0);
        run_pix("miss_l", 99, 50, 0, 0, 0, 0);
        run_pix("miss_b", 100, 82, 0, 0, 0, 0);
        rom_force_key = 1'b1;
        run_pix("key", 100, 50, 0, 2048, 0, 0);
        rom_force_key = 1'b0;

        char_x = 10'd200;
        run_pix("tear_old", 100, 50, 0, 2048, 1, 'h123);
        run_pix("tear_new", 200, 50, 0, 0, 0, 0);
        run_pix("fs_same", 100, 50, 1, 2048, 1, 'h123);
        run_pix("after_fs", 200, 50, 0, 2048, 1, 'h123);
        run_pix("after_fs_old", 100, 50, 0, 0, 0, 0);

        frame(2, 1, 100, 50);
        run_pix("mir0", 100, 50, 0, 2079, 1, 'h13C);
        run_pix("mir31", 131, 50, 0, 2048, 1, 'h123);

        frame(1, 0, 1010, 1000);
        run_pix("clip_in", 1020, 1005, 0, 1194, 1, 'h589);
        run_pix("wrap_x", 0, 1005, 0, 0, 0, 0);
        run_pix("wrap_y", 1020, 0, 0, 0, 0, 0);

        frame(2, 0, 100, 50);
        for (int c = 0; c < 7; c++) begin
            if (c < 5 && st_x[c] >= 0) begin
                pix_valid = 1'b1;
                pix_x = 10'(st_x[c]);
                pix_y = 10'(st_y[c]);
            end else begin
                pix_valid = 1'b0;
            end
            step();
            if (c >= 2) begin
                chk($sformatf("stream%0d.vld", c - 2), 32'(out_valid), (st_x[c-2] >= 0) ? 32'd1 : 32'd0);
                chk($sformatf("stream%0d.hit", c - 2), 32'(out_hit), 32'(st_hit[c-2]));
                chk($sformatf("stream%0d.col", c - 2), 32'(out_color), 32'(st_col[c-2]));
            end
        end
        pix_valid = 1'b0;

        frame(7, 0, 100, 50);
        run_pix("id7_a", 100, 50, 0, 0, 0, 0);
        run_pix("id7_b", 131, 81, 0, 0, 0, 0);
        run_pix("id7_c", 110, 60, 0, 0, 0, 0);

        pix_x = 10'd100;
        pix_y = 10'd50;
        pix_valid = 1'b1;
        step();
        pix_x = 10'd101;
        step();
        pix_valid = 1'b0;
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk("inflight.vld0", 32'(out_valid), 32'd0);
        chk("inflight.addr", 32'(rom_addr), 32'd0);
        step();
        chk("inflight.vld1", 32'(out_valid), 32'd0);
        step();
        chk("inflight.vld2", 32'(out_valid), 32'd0);
        run_pix("post_rst", 0, 0, 0, 0, 1, 'h123);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
